// File: rtl/rv_mc_pkg.sv
// Shared definitions for the multicycle core: MAU state encodings and default bus widths.
package rv_mc_pkg;

  localparam int RV_ADDR_W = 32;
  localparam int RV_DATA_W = 32;

  typedef enum logic [1:0] {
    MAU_IDLE   = 2'd0,
    MAU_ISSUE  = 2'd1,
    MAU_WAIT_R = 2'd2,
    MAU_DONE   = 2'd3
  } mau_state_e;

  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/mau_timeout.sv
// 8-bit access timeout counter: synchronous clear, count enable, and a terminal-count flag
// raised in the cycle whose increment would take the count from LAST to LAST+1.
module mau_timeout #(
  parameter logic [7:0] LAST = 8'd253
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = 8'd0;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  // NOTE: reset is synchronous (sampled on the clock edge), and state updates use <= so
  // every flop sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

  assign tc = en && (cnt_q == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Memory access sequencer: latches one read/write request, runs the bus req/gnt/rvalid
// handshake, bounds it with a timeout. Optional macro: MAU_MISALIGN_CHECK_EN.
module mem_access_unit
  import rv_mc_pkg::*;
#(
  parameter int ADDR_W  = RV_ADDR_W,
  parameter int DATA_W  = RV_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              busy,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  mau_state_e        state_q,     state_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              err_q,       err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic tmo_clr, tmo_en, tmo_tc;

  assign tmo_en = (state_q == MAU_ISSUE) || (state_q == MAU_WAIT_R);

  // The counter reaches TIMEOUT-1 on the same edge that moves the FSM to DONE,
  // so terminal count is flagged while the count still holds TIMEOUT-2.
  mau_timeout #(
    .LAST (8'(TIMEOUT - 2))
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .tc     (tmo_tc)
  );

  always_comb begin
    // NOTE: every variable gets a default here so no path through the case infers a latch.
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    err_d       = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    tmo_clr     = 1'b0;

    case (state_q)
      MAU_IDLE: begin
        if (req_valid) begin
          mem_we_d    = req_write;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata;
          tmo_clr     = 1'b1;
`ifdef MAU_MISALIGN_CHECK_EN
          if (is_misaligned(req_addr[1:0])) begin
            state_d     = MAU_DONE;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
          end else begin
            state_d   = MAU_ISSUE;
            mem_req_d = 1'b1;
          end
`else
          state_d   = MAU_ISSUE;
          mem_req_d = 1'b1;
`endif
        end
      end

      MAU_ISSUE: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d     = MAU_DONE;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = MAU_WAIT_R;
          end
        end else if (tmo_tc) begin
          state_d     = MAU_DONE;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          err_d       = 1'b1;
        end
      end

      MAU_WAIT_R: begin
        if (mem_rvalid) begin
          state_d     = MAU_DONE;
          rsp_rdata_d = mem_rdata;
          rsp_valid_d = 1'b1;
        end else if (tmo_tc) begin
          state_d     = MAU_DONE;
          rsp_valid_d = 1'b1;
          err_d       = 1'b1;
        end
      end

      MAU_DONE: state_d = MAU_IDLE;

      default: state_d = MAU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= MAU_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == MAU_IDLE);
  assign busy      = (state_q != MAU_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign err       = err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT=8); expectations follow
// MAU_MISALIGN_CHECK_EN when the macro is defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, busy, rsp_valid, err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step(); step();
    resetn = 1'b1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_mem_req",   32'(mem_req),   32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_rsp_rdata", rsp_rdata,      32'h0);
    check("rst_mem_addr",  mem_addr,       32'h0);

    // Zero-wait read
    request(1'b0, 32'h0000_0010, 32'h0);
    step();                                         // edge 0: accept
    req_valid = 1'b0;
    check("rd0_c1_mem_req",  32'(mem_req),   32'd1);
    check("rd0_c1_addr",     mem_addr,       32'h0000_0010);
    check("rd0_c1_we",       32'(mem_we),    32'd0);
    check("rd0_c1_ready",    32'(req_ready), 32'd0);
    mem_gnt = 1'b1;
    step();                                         // edge 1: grant
    mem_gnt = 1'b0;
    check("rd0_c2_mem_req",  32'(mem_req),   32'd0);
    check("rd0_c2_rsp",      32'(rsp_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();                                         // edge 2: rvalid
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check("rd0_c3_rsp",      32'(rsp_valid), 32'd1);
    check("rd0_c3_rdata",    rsp_rdata,      32'hDEAD_BEEF);
    check("rd0_c3_err",      32'(err),       32'd0);
    check("rd0_c3_busy",     32'(busy),      32'd1);
    step();
    check("rd0_c4_rsp",      32'(rsp_valid), 32'd0);
    check("rd0_c4_ready",    32'(req_ready), 32'd1);
    check("rd0_c4_rdata",    rsp_rdata,      32'hDEAD_BEEF);

    // Write with grant delayed 3 cycles: 4 ISSUE cycles
    request(1'b1, 32'h0000_0020, 32'h1234_5678);
    step();
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("wr_c%0d_mem_req", c), 32'(mem_req),   32'd1);
      check($sformatf("wr_c%0d_we", c),      32'(mem_we),    32'd1);
      check($sformatf("wr_c%0d_addr", c),    mem_addr,       32'h0000_0020);
      check($sformatf("wr_c%0d_wdata", c),   mem_wdata,      32'h1234_5678);
      check($sformatf("wr_c%0d_rsp", c),     32'(rsp_valid), 32'd0);
      if (c == 4) mem_gnt = 1'b1;
      step();
    end
    mem_gnt = 1'b0;
    check("wr_c5_rsp",     32'(rsp_valid), 32'd1);
    check("wr_c5_err",     32'(err),       32'd0);
    check("wr_c5_mem_req", 32'(mem_req),   32'd0);
    check("wr_c5_rdata",   rsp_rdata,      32'hDEAD_BEEF);
    step();
    check("wr_c6_rsp",     32'(rsp_valid), 32'd0);
    check("wr_c6_ready",   32'(req_ready), 32'd1);

    // Read timeout: no grant, TIMEOUT=8 -> rsp_valid+err in cycle 8
    request(1'b0, 32'h0000_0030, 32'h0);
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("to_c%0d_rsp", c),     32'(rsp_valid), 32'd0);
      check($sformatf("to_c%0d_mem_req", c), 32'(mem_req),   32'd1);
      step();
    end
    check("to_c8_rsp",     32'(rsp_valid), 32'd1);
    check("to_c8_err",     32'(err),       32'd1);
    check("to_c8_mem_req", 32'(mem_req),   32'd0);
    check("to_c8_rdata",   rsp_rdata,      32'hDEAD_BEEF);
    step();
    check("to_c9_rsp",     32'(rsp_valid), 32'd0);
    check("to_c9_err",     32'(err),       32'd0);
    check("to_c9_ready",   32'(req_ready), 32'd1);

    // Grant on the terminal-count cycle wins
    request(1'b1, 32'h0000_0040, 32'hA5A5_A5A5);
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 7) mem_gnt = 1'b1;
      step();
    end
    mem_gnt = 1'b0;
    check("gtc_rsp", 32'(rsp_valid), 32'd1);
    check("gtc_err", 32'(err),       32'd0);
    step();

    // Rvalid on the terminal-count cycle wins
    request(1'b0, 32'h0000_0044, 32'h0);
    step();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    step();                                         // WAIT_R from cycle 2
    mem_gnt = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      if (c == 7) begin mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; end
      step();
    end
    mem_rvalid = 1'b0;
    check("rtc_rsp",   32'(rsp_valid), 32'd1);
    check("rtc_err",   32'(err),       32'd0);
    check("rtc_rdata", rsp_rdata,      32'hCAFE_F00D);
    step();

    // Rvalid coincident with grant is ignored
    request(1'b0, 32'h0000_0048, 32'h0);
    step();
    req_valid = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    step();
    check("coin_c3_rsp",  32'(rsp_valid), 32'd0);
    check("coin_c3_busy", 32'(busy),      32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
    step();
    mem_rvalid = 1'b0;
    check("coin_c4_rsp",   32'(rsp_valid), 32'd1);
    check("coin_c4_rdata", rsp_rdata,      32'h2222_2222);
    step();

    // Reset in WAIT_R, then a late rvalid
    request(1'b0, 32'h0000_004C, 32'h0);
    step();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    check("rstw_busy",    32'(busy),      32'd0);
    check("rstw_ready",   32'(req_ready), 32'd1);
    check("rstw_mem_req", 32'(mem_req),   32'd0);
    check("rstw_addr",    mem_addr,       32'h0);
    check("rstw_rdata",   rsp_rdata,      32'h0);
    step();
    mem_rvalid = 1'b0;
    check("rstw_late_rsp",   32'(rsp_valid), 32'd0);
    check("rstw_late_rdata", rsp_rdata,      32'h0);
    check("rstw_late_busy",  32'(busy),      32'd0);

    // Misaligned read
    request(1'b0, 32'h0000_0013, 32'h0);
    step();
    req_valid = 1'b0;
`ifdef MAU_MISALIGN_CHECK_EN
    check("mis_c1_mem_req", 32'(mem_req),   32'd0);
    check("mis_c1_rsp",     32'(rsp_valid), 32'd1);
    check("mis_c1_err",     32'(err),       32'd1);
    check("mis_c1_rdata",   rsp_rdata,      32'h0);
    step();
    check("mis_c2_ready",   32'(req_ready), 32'd1);
    check("mis_c2_mem_req", 32'(mem_req),   32'd0);
`else
    check("mis_c1_mem_req", 32'(mem_req),   32'd1);
    check("mis_c1_addr",    mem_addr,       32'h0000_0013);
    check("mis_c1_rsp",     32'(rsp_valid), 32'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_rvalid = 1'b0;
    check("mis_c3_rsp",   32'(rsp_valid), 32'd1);
    check("mis_c3_err",   32'(err),       32'd0);
    check("mis_c3_rdata", rsp_rdata,      32'h0BAD_F00D);
    step();
`endif

    // Back-to-back reads with req_valid held high
    request(1'b0, 32'h0000_0050, 32'h0);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0A0A_0A0A;
    step();                                         // edge 0: first accept
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("b2b_c%0d_ready", c), 32'(req_ready), 32'd0);
      check($sformatf("b2b_c%0d_rsp", c),   32'(rsp_valid), (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) req_addr = 32'h0000_0054;
      step();
    end
    check("b2b_c4_ready",   32'(req_ready), 32'd1);
    check("b2b_c4_rsp",     32'(rsp_valid), 32'd0);
    check("b2b_c4_mem_req", 32'(mem_req),   32'd0);
    check("b2b_c4_rdata",   rsp_rdata,      32'h0A0A_0A0A);
    step();                                         // edge 4: second accept
    req_valid = 1'b0;
    mem_rdata = 32'h0B0B_0B0B;
    check("b2b_c5_mem_req", 32'(mem_req),   32'd1);
    check("b2b_c5_addr",    mem_addr,       32'h0000_0054);
    check("b2b_c5_ready",   32'(req_ready), 32'd0);
    step();
    check("b2b_c6_ready",   32'(req_ready), 32'd0);
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("b2b_c7_rsp",     32'(rsp_valid), 32'd1);
    check("b2b_c7_rdata",   rsp_rdata,      32'h0B0B_0B0B);
    check("b2b_c7_ready",   32'(req_ready), 32'd0);
    step();
    check("b2b_c8_ready",   32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access sequencer between the multicycle control unit and the external memory bus. The control unit raises a single-word read (instruction fetch, LW data read) or write (SW) request. This block latches the request, drives the bus request/grant handshake, and waits for read data. It returns a one-cycle completion with registered read data, and holds `busy` so the control unit stalls in its current state until the access completes. It also bounds every access with a timeout.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles spent in ISSUE+WAIT_R before abort; must be ≥2 and <256

- clk  in  1  clock, rising edge
- resetn  in  1  synchronous, active-low reset
- req_valid  in  1  access request from control unit
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_ready  out  1  high in IDLE; request accepted when req_valid & req_ready
- busy  out  1  high in every state except IDLE
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  last read data; held between completions
- err  out  1  one-cycle pulse coincident with an aborted rsp_valid
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  DATA_W  bus write data
- mem_gnt  in  1  bus grant, sampled only while mem_req=1
- mem_rvalid  in  1  read data valid, sampled only in WAIT_R
- mem_rdata  in  DATA_W  bus read data

## Operation
- States: IDLE, ISSUE, WAIT_R, DONE (2-bit encoding).
- IDLE: on req_valid, latch addr, write flag and wdata, clear the timeout counter, and go to ISSUE. With req_valid low, stay in IDLE.
- ISSUE: mem_req=1. mem_we, mem_addr and mem_wdata come from the latched values and are stable until grant.
  - mem_gnt with a write goes to DONE.
  - mem_gnt with a read goes to WAIT_R.
- WAIT_R: on mem_rvalid, capture mem_rdata into rsp_rdata and go to DONE. A mem_rvalid in the same cycle as mem_gnt (in ISSUE) is ignored.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. A new request is never accepted in DONE.
- Timeout: the counter increments each cycle in ISSUE and WAIT_R. When the count reaches TIMEOUT-1 without a grant or rvalid, go to DONE with err=1, drop mem_req, and leave rsp_rdata unchanged.
- A grant or rvalid in the same cycle as the timeout terminal count wins. The access completes normally with err=0.
- mem_rvalid in IDLE, ISSUE or DONE is ignored. mem_gnt while mem_req=0 is ignored.
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, rsp_valid 0, rsp_rdata 0, err 0, counter 0. With those values req_ready=1 and busy=0.
- Reset asserted mid-access aborts at the next edge. Any late gnt or rvalid after that is ignored.

## Timing
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- Zero-wait write: accept at edge 0, ISSUE with gnt sampled at edge 1, rsp_valid high in cycle 2. Three cycles total.
- Zero-wait read: accept at edge 0, gnt at edge 1, rvalid at edge 2, rsp_valid high in cycle 3, with rsp_rdata valid that same cycle.
- Back-to-back throughput is one access per 4 cycles for reads and per 3 cycles for writes. The extra IDLE cycle is required.

## Configuration
- MAU_MISALIGN_CHECK_EN defined:
  - A request with req_addr[1:0]≠0 is accepted but never issued.
  - The FSM goes IDLE→DONE directly with err=1 and rsp_rdata unchanged. mem_req stays 0.
- MAU_MISALIGN_CHECK_EN undefined: the address is passed to the bus unmodified and no alignment check is made.

## Structure
- Shared package/header `rv_mc_pkg`: MAU state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT_R=2'd2, DONE=2'd3) and the default ADDR_W/DATA_W constants, shared with the control unit.
- One sub-module, `mau_timeout`: 8-bit counter with clear, enable and terminal-count output, reset to 0.

## Test plan
- Read 0x0000_0010, gnt and rvalid with zero wait, mem_rdata=0xDEADBEEF → rsp_valid in cycle 3, rsp_rdata=0xDEADBEEF, err=0.
- Write 0x0000_0020 with data 0x12345678, gnt delayed 3 cycles → mem_addr and mem_wdata stable for all 4 ISSUE cycles, then a single rsp_valid with err=0.
- Read with gnt never asserted, TIMEOUT=8 → rsp_valid and err high together 8 cycles after accept, mem_req deasserted, rsp_rdata keeps its previous value.
- Reset pulsed while in WAIT_R, then rvalid arrives → returns to IDLE with all outputs at reset values, and no rsp_valid is produced.
- With MAU_MISALIGN_CHECK_EN, read 0x0000_0013 → mem_req never asserted, rsp_valid and err high at cycle 1. Without the macro, mem_addr=0x0000_0013 is issued.
- req_valid held high across two back-to-back reads → the second request is accepted only in the cycle after DONE, and req_ready is low throughout ISSUE, WAIT_R and DONE.
